// File: rtl/lsq_request_issuer_pkg.sv
// Shared types for the load/store request issuer: response metadata, load
// size encodings and the load-result alignment helper.
package lsq_request_issuer_pkg;

  typedef logic [3:0] id_t;

  typedef struct packed {
    id_t        id;
    logic [2:0] fn3;
    logic [1:0] offset;
  } lsq_rsp_meta_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Move the addressed byte/half down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [2:0]  fn3,
                                             input logic [1:0]  offset);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (fn3)
      LS_B:    align_load = {{24{shifted[7]}}, shifted[7:0]};
      LS_H:    align_load = {{16{shifted[15]}}, shifted[15:0]};
      LS_BU:   align_load = {24'd0, shifted[7:0]};
      LS_HU:   align_load = {16'd0, shifted[15:0]};
      LS_W:    align_load = word;
      default: align_load = word;
    endcase
  endfunction

endpackage

// File: rtl/lsq_request_issuer_load_tracker.sv
// In-order tracker for outstanding loads/AMOs: metadata FIFO filled at issue,
// data FIFO filled by memory responses, results formed from both heads.
module lsq_request_issuer_load_tracker
  import lsq_request_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  lsq_rsp_meta_t push_meta,
  input  logic          rsp_valid,
  input  logic [31:0]   rsp_data,
  input  logic          ack,
  output logic          full,
  output logic          done,
  output id_t           done_id,
  output logic [31:0]   done_data,
  output logic          idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  lsq_rsp_meta_t meta_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] meta_wr, meta_rd, data_wr, data_rd, count;
  logic          data_push, pop;
  lsq_rsp_meta_t head_meta;

  // Meta entries live from issue until writeback ack, so they are the credit count.
  assign count     = meta_wr - meta_rd;
  assign full      = (count == PW'(DEPTH));
  assign idle      = (count == '0);
  assign done      = (data_wr != data_rd);
  assign pop       = done & ack;
  assign data_push = rsp_valid & ~idle;

  assign head_meta = meta_mem[meta_rd[AW-1:0]];
  assign done_id   = head_meta.id;
  assign done_data = align_load(data_mem[data_rd[AW-1:0]], head_meta.fn3, head_meta.offset);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_wr <= '0;
      meta_rd <= '0;
      data_wr <= '0;
      data_rd <= '0;
    end else begin
      if (push)      meta_wr <= meta_wr + 1'b1;
      if (data_push) data_wr <= data_wr + 1'b1;
      if (pop) begin
        meta_rd <= meta_rd + 1'b1;
        data_rd <= data_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)      meta_mem[meta_wr[AW-1:0]] <= push_meta;
    if (data_push) data_mem[data_wr[AW-1:0]] <= rsp_data;
  end

  // A response with nothing outstanding is dropped above; flag it loudly.
  rsp_without_request: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> !idle);

endmodule

// File: rtl/lsq_request_issuer.sv
// Consumer end of the load/store queue: zero-cycle issue of the queue head to
// data memory, blocking loads only when the load tracker has no credit left.
module lsq_request_issuer
  import lsq_request_issuer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = $bits(id_t)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsq_valid,
  input  logic            lsq_load,
  input  logic            lsq_store,
  input  logic [31:0]     lsq_addr,
  input  logic [3:0]      lsq_be,
  input  logic [2:0]      lsq_fn3,
  input  logic [31:0]     lsq_data,
  input  logic [ID_W-1:0] lsq_id,
  output logic            lsq_pop,
  output logic            mem_req,
  input  logic            mem_ready,
  output logic [31:0]     mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  output logic            mem_needs_rsp,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [31:0]     wb_data,
  input  logic            wb_ack,
  output logic            idle
);
  logic          needs_rsp, blocked, tracker_full, issue;
  lsq_rsp_meta_t issue_meta;
  id_t           tracker_id;

  // Full tracker is checked against the registered count, so a same-cycle ack
  // only frees the credit for the following cycle.
  assign needs_rsp = lsq_load;
  assign blocked   = needs_rsp & tracker_full;
  assign mem_req   = lsq_valid & ~blocked & ~rst;
  assign lsq_pop   = mem_req & mem_ready;
  assign issue     = lsq_pop & needs_rsp;

  assign mem_addr      = {lsq_addr[31:2], 2'b00};
  assign mem_we        = lsq_store;
  assign mem_be        = lsq_be;
  assign mem_wdata     = lsq_data;
  assign mem_needs_rsp = needs_rsp;

  assign issue_meta = '{id: id_t'(lsq_id), fn3: lsq_fn3, offset: lsq_addr[1:0]};
  assign wb_id      = ID_W'(tracker_id);

  lsq_request_issuer_load_tracker #(
    .DEPTH(MAX_OUTSTANDING)
  ) tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_meta (issue_meta),
    .rsp_valid (mem_rvalid),
    .rsp_data  (mem_rdata),
    .ack       (wb_ack),
    .full      (tracker_full),
    .done      (wb_done),
    .done_id   (tracker_id),
    .done_data (wb_data),
    .idle      (idle)
  );

endmodule
